// File: rtl/uart_cmd_ctrl.sv
// UART command frame decoder: SYNC, ADDR, DATA, CHK -> single-cycle register write.
// CHK is the modulo-256 sum of ADDR and DATA. Bad checksums and inter-byte timeouts
// raise a one-cycle error pulse and bump a saturating error counter.
module uart_cmd_ctrl #(
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
  parameter int unsigned TIMEOUT_CLKS = 21700
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_dv_i,
  input  logic [7:0] rx_byte_i,
  output logic       wr_en_o,
  output logic [7:0] wr_addr_o,
  output logic [7:0] wr_data_o,
  output logic       frame_ok_o,
  output logic       frame_err_o,
  output logic       busy_o,
  output logic [7:0] err_count_o
);

  localparam int unsigned TmoW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CLKS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StGetAddr,
    StGetData,
    StGetChk,
    StCommit
  } state_e;

  state_e          state_q;
  logic [7:0]      addr_q;
  logic [7:0]      data_q;
  logic [TmoW-1:0] tmo_q;
  logic            wr_en_q;
  logic [7:0]      wr_addr_q;
  logic [7:0]      wr_data_q;
  logic            frame_ok_q;
  logic            frame_err_q;
  logic            busy_q;
  logic [7:0]      err_count_q;

  logic [7:0]      chk_d;
  logic [7:0]      err_count_d;

  // Expected checksum and saturated error count, used by the FSM below.
  always_comb begin
    chk_d       = addr_q + data_q;
    err_count_d = (err_count_q == 8'hFF) ? err_count_q : err_count_q + 8'd1;
  end

  // Frame FSM with registered outputs; busy/strobes are set alongside the next state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      data_q      <= '0;
      tmo_q       <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
      err_count_q <= '0;
    end else begin
      wr_en_q     <= 1'b0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      unique case (state_q)
        // COMMIT accepts a new SYNC exactly like IDLE so back-to-back frames lose nothing.
        StIdle, StCommit: begin
          if (rx_dv_i && (rx_byte_i == SYNC_BYTE)) begin
            state_q <= StGetAddr;
            busy_q  <= 1'b1;
            tmo_q   <= '0;
          end else begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        end
        StGetAddr, StGetData, StGetChk: begin
          // A byte arriving on the last timeout cycle wins over the timeout.
          if (rx_dv_i) begin
            tmo_q <= '0;
            if (state_q == StGetAddr) begin
              addr_q  <= rx_byte_i;
              state_q <= StGetData;
            end else if (state_q == StGetData) begin
              data_q  <= rx_byte_i;
              state_q <= StGetChk;
            end else if (rx_byte_i == chk_d) begin
              state_q    <= StCommit;
              busy_q     <= 1'b0;
              wr_en_q    <= 1'b1;
              frame_ok_q <= 1'b1;
              wr_addr_q  <= addr_q;
              wr_data_q  <= data_q;
            end else begin
              state_q     <= StIdle;
              busy_q      <= 1'b0;
              frame_err_q <= 1'b1;
              err_count_q <= err_count_d;
            end
          end else if (tmo_q == TmoLast) begin
            state_q     <= StIdle;
            busy_q      <= 1'b0;
            tmo_q       <= '0;
            frame_err_q <= 1'b1;
            err_count_q <= err_count_d;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign wr_en_o     = wr_en_q;
  assign wr_addr_o   = wr_addr_q;
  assign wr_data_o   = wr_data_q;
  assign frame_ok_o  = frame_ok_q;
  assign frame_err_o = frame_err_q;
  assign busy_o      = busy_q;
  assign err_count_o = err_count_q;

endmodule
